spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 170 +++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-requester round-robin arbiter driving a byte-level SPI engine for
// flash transactions: opcode, optional 3-byte address, then N read bytes.
module spi_flash_arbiter #(
  parameter int unsigned CS_GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic        use_addr0,
  input  logic        use_addr1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        done0,
  output logic        done1,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        spi_send,
  output logic        spi_recv,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_ready,
  output logic        spi_cs
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR_H, ADDR_M, ADDR_L, READ, END, GAP} state_t;
  typedef enum logic [1:0] {PULSE, SKIP, WAIT} phase_t;

  state_t      state, next_byte_state;
  phase_t      phase;
  logic        last_gnt;   // also identifies the current owner while a transaction runs
  logic        pick;
  logic [7:0]  cmd_q;
  logic [23:0] addr_q;
  logic        use_addr_q;
  logic [7:0]  rem;
  logic [3:0]  gap_cnt;
  logic [7:0]  tx_byte;

  assign pick = (req0 && req1) ? ~last_gnt : req1;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    tx_byte         = 8'hFF;
    next_byte_state = IDLE;
    case (state)
      CMD: begin
        tx_byte         = cmd_q;
        next_byte_state = use_addr_q ? ADDR_H : ((rem == 8'd0) ? END : READ);
      end
      ADDR_H: begin
        tx_byte         = addr_q[23:16];
        next_byte_state = ADDR_M;
      end
      ADDR_M: begin
        tx_byte         = addr_q[15:8];
        next_byte_state = ADDR_L;
      end
      ADDR_L: begin
        tx_byte         = addr_q[7:0];
        next_byte_state = (rem == 8'd0) ? END : READ;
      end
      READ:    next_byte_state = (rem == 8'd1) ? END : READ;
      default: next_byte_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= PULSE;
      last_gnt   <= 1'b1;
      cmd_q      <= 8'h00;
      addr_q     <= 24'h0;
      use_addr_q <= 1'b0;
      rem        <= 8'h00;
      gap_cnt    <= 4'h0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      spi_send   <= 1'b0;
      spi_recv   <= 1'b0;
      spi_tx     <= 8'hFF;
      spi_cs     <= 1'b1;
    end else begin
      // Strobes default low; each branch raises only what it needs.
      spi_send <= 1'b0;
      spi_recv <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            last_gnt   <= pick;
            cmd_q      <= pick ? cmd1 : cmd0;
            addr_q     <= pick ? addr1 : addr0;
            use_addr_q <= pick ? use_addr1 : use_addr0;
            rem        <= pick ? len1 : len0;
            gnt0       <= ~pick;
            gnt1       <= pick;
            busy       <= 1'b1;
            spi_cs     <= 1'b0;
            phase      <= PULSE;
            state      <= CMD;
          end
        end
        CMD, ADDR_H, ADDR_M, ADDR_L, READ: begin
          case (phase)
            PULSE: begin
              spi_tx <= tx_byte;
              if (state == READ) spi_recv <= 1'b1;
              else               spi_send <= 1'b1;
              phase <= SKIP;
            end
            // The engine may not have dropped spi_ready yet in this cycle.
            SKIP: phase <= WAIT;
            default: begin
              if (spi_ready) begin
                phase <= PULSE;
                state <= next_byte_state;
                if (state == READ) begin
                  rdata   <= spi_rx;
                  rvalid0 <= ~last_gnt;
                  rvalid1 <= last_gnt;
                  rem     <= rem - 8'd1;
                end
              end
            end
          endcase
        end
        END: begin
          spi_cs  <= 1'b1;
          done0   <= ~last_gnt;
          done1   <= last_gnt;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          gap_cnt <= 4'(CS_GAP - 1);
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed self-checking bench for spi_flash_arbiter with a simple byte-engine
// model and a negedge monitor that logs the SPI byte stream and strobes.
module tb_spi_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  cmd0, cmd1;
  logic [23:0] addr0, addr1;
  logic        use_addr0, use_addr1;
  logic [7:0]  len0, len1;
  logic        gnt0, gnt1, rvalid0, rvalid1, done0, done1;
  logic [7:0]  rdata;
  logic        busy, spi_send, spi_recv, spi_cs;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_flash_arbiter #(.CS_GAP(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .cmd0(cmd0), .cmd1(cmd1),
    .addr0(addr0), .addr1(addr1), .use_addr0(use_addr0), .use_addr1(use_addr1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy), .spi_send(spi_send), .spi_recv(spi_recv),
    .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_ready(spi_ready), .spi_cs(spi_cs)
  );

  // Byte engine: goes busy on a pulse, returns ready after eng_delay+1 cycles.
  int         eng_delay = 2;
  int         ecnt;
  logic [7:0] rx_bytes [8];
  int         rx_idx = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_ready <= 1'b1;
      spi_rx    <= 8'h00;
      ecnt      <= 0;
    end else if (spi_send || spi_recv) begin
      spi_ready <= 1'b0;
      ecnt      <= eng_delay;
      if (spi_recv) begin
        spi_rx <= rx_bytes[rx_idx & 7];
        rx_idx <= rx_idx + 1;
      end
    end else if (!spi_ready) begin
      if (ecnt == 0) spi_ready <= 1'b1;
      else           ecnt <= ecnt - 1;
    end
  end

  // Monitor
  logic [7:0] tx_log[$], rv0_log[$], rv1_log[$];
  logic [7:0] grant_log[$];
  int send_cnt, recv_cnt, done0_cnt, done1_cnt, viol, cyc;
  int grant_cyc, first_send_cyc, cs_run, min_gap;
  logic gnt0_seen, prev_g = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (spi_send || spi_recv) tx_log.push_back(spi_tx);
    if (spi_send) send_cnt++;
    if (spi_recv) recv_cnt++;
    if (rvalid0) rv0_log.push_back(rdata);
    if (rvalid1) rv1_log.push_back(rdata);
    if (done0) done0_cnt++;
    if (done1) done1_cnt++;
    if (gnt0 && gnt1) viol++;
    if (spi_send && spi_recv) viol++;
    if ((rvalid0 && !gnt0) || (rvalid1 && !gnt1)) viol++;
    if ((gnt0 || gnt1) && spi_cs) viol++;
    if (gnt0) gnt0_seen = 1'b1;
    if ((gnt0 || gnt1) && !prev_g) begin
      grant_log.push_back({7'd0, gnt1});
      grant_cyc = cyc;
    end
    prev_g = gnt0 | gnt1;
    if (spi_send && first_send_cyc < 0) first_send_cyc = cyc;
    if (spi_cs) cs_run++;
    else begin
      if (cs_run > 0 && cs_run < min_gap) min_gap = cs_run;
      cs_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic clear_logs();
    tx_log.delete(); rv0_log.delete(); rv1_log.delete(); grant_log.delete();
    send_cnt = 0; recv_cnt = 0; done0_cnt = 0; done1_cnt = 0; viol = 0;
    gnt0_seen = 1'b0; first_send_cyc = -1; grant_cyc = 0;
    min_gap = 1000; rx_idx = 0;
  endtask

  task automatic set_req(input int which, input logic [7:0] cmd, input logic [23:0] addr,
                         input logic use_addr, input logic [7:0] len);
    if (which == 0) begin
      cmd0 = cmd; addr0 = addr; use_addr0 = use_addr; len0 = len; req0 = 1'b1;
    end else begin
      cmd1 = cmd; addr1 = addr; use_addr1 = use_addr; len1 = len; req1 = 1'b1;
    end
  endtask

  // Wait for grant, then drop req and scramble the request fields.
  task automatic release_after_grant(input int which, input int budget);
    int n = 0;
    while (!(which == 0 ? gnt0 : gnt1) && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) check("grant_timeout", 0, 1);
    if (which == 0) begin
      req0 = 1'b0; cmd0 = 8'hAA; addr0 = 24'hDEAD00; len0 = 8'd9; use_addr0 = ~use_addr0;
    end else begin
      req1 = 1'b0; cmd1 = 8'hAA; addr1 = 24'hDEAD00; len1 = 8'd9; use_addr1 = ~use_addr1;
    end
  endtask

  task automatic wait_done(input int which, input int budget);
    int n = 0;
    int start = (which == 0) ? done0_cnt : done1_cnt;
    while (((which == 0) ? done0_cnt : done1_cnt) == start && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) check("done_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); n++;
    end
    if (n >= budget) check("idle_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; addr0 = 0; addr1 = 0;
    use_addr0 = 0; use_addr1 = 0; len0 = 0; len1 = 0;
    clear_logs();
    cs_run = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs", spi_cs, 1);
    check("rst_tx", spi_tx, 8'hFF);
    check("rst_gnt", {gnt0, gnt1}, 0);
    check("rst_strobes", {spi_send, spi_recv, rvalid0, rvalid1, done0, done1}, 0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // JEDEC ID read
    clear_logs();
    rx_bytes[0] = 8'hEF; rx_bytes[1] = 8'h40; rx_bytes[2] = 8'h18;
    set_req(0, 8'h9F, 24'h0, 1'b0, 8'd3);
    release_after_grant(0, 10);
    wait_done(0, 200);
    check("jedec_latency", first_send_cyc - grant_cyc, 1);
    check_log("jedec_tx", tx_log, '{8'h9F, 8'hFF, 8'hFF, 8'hFF});
    check("jedec_sends", send_cnt, 1);
    check("jedec_recvs", recv_cnt, 3);
    check_log("jedec_rv0", rv0_log, '{8'hEF, 8'h40, 8'h18});
    check("jedec_done0", done0_cnt, 1);
    check("jedec_rv1", rv1_log.size(), 0);
    repeat (4) begin
      check("jedec_gap_cs", spi_cs, 1);
      @(negedge clk);
    end
    wait_idle(20);
    check("jedec_viol", viol, 0);

    // Addressed read from requester 1
    clear_logs();
    rx_bytes[0] = 8'hA5; rx_bytes[1] = 8'h5A;
    set_req(1, 8'h03, 24'h123456, 1'b1, 8'd2);
    release_after_grant(1, 10);
    wait_done(1, 300);
    check_log("addr_tx", tx_log, '{8'h03, 8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF});
    check_log("addr_rv1", rv1_log, '{8'hA5, 8'h5A});
    check("addr_gnt0_seen", gnt0_seen, 0);
    wait_idle(20);
    check("addr_done1", done1_cnt, 1);
    check("addr_viol", viol, 0);

    // Contention straight out of reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    set_req(0, 8'h05, 24'h0, 1'b0, 8'd1);
    set_req(1, 8'h35, 24'h0, 1'b0, 8'd1);
    begin
      int n = 0;
      while (grant_log.size() < 3 && n < 500) begin
        @(negedge clk); n++;
      end
      if (n >= 500) check("contention_timeout", 0, 1);
    end
    req0 = 0; req1 = 0;
    check_log("contention_order", grant_log, '{8'd0, 8'd1, 8'd0});
    check("contention_gap", min_gap >= 4, 1);
    wait_idle(200);
    check("contention_viol", viol, 0);

    // Zero-length command (write enable)
    clear_logs();
    set_req(0, 8'h06, 24'h0, 1'b0, 8'd0);
    release_after_grant(0, 10);
    wait_done(0, 100);
    check_log("wren_tx", tx_log, '{8'h06});
    check("wren_sends", send_cnt, 1);
    check("wren_recvs", recv_cnt, 0);
    check("wren_rv0", rv0_log.size(), 0);
    check("wren_done0", done0_cnt, 1);
    wait_idle(20);

    // Abort during the ADDR_M wait
    clear_logs();
    eng_delay = 10;
    set_req(0, 8'h03, 24'hABCDEF, 1'b1, 8'd2);
    release_after_grant(0, 10);
    begin
      int n = 0;
      while (send_cnt < 3 && n < 200) begin
        @(negedge clk); n++;
      end
      if (n >= 200) check("abort_timeout", 0, 1);
    end
    check("abort_at_addr_m", tx_log.size() > 0 ? tx_log[tx_log.size()-1] : 8'h00, 8'hCD);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_cs", spi_cs, 1);
    check("abort_gnt", {gnt0, gnt1}, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    eng_delay = 2;
    clear_logs();
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22;
    set_req(0, 8'h9F, 24'h0, 1'b0, 8'd2);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", gnt0, 1);
    check("abort_no_done", done0_cnt, 0);
    release_after_grant(0, 10);
    wait_done(0, 200);
    check_log("post_rst_tx", tx_log, '{8'h9F, 8'hFF, 8'hFF});
    check_log("post_rst_rv0", rv0_log, '{8'h11, 8'h22});
    check("post_rst_done0", done0_cnt, 1);
    wait_idle(20);

    // Slow engine
    clear_logs();
    eng_delay = 50;
    rx_bytes[0] = 8'hC3; rx_bytes[1] = 8'h3C;
    set_req(1, 8'h0B, 24'hABCDEF, 1'b1, 8'd2);
    release_after_grant(1, 10);
    wait_done(1, 2000);
    check_log("slow_tx", tx_log, '{8'h0B, 8'hAB, 8'hCD, 8'hEF, 8'hFF, 8'hFF});
    check("slow_sends", send_cnt, 4);
    check("slow_recvs", recv_cnt, 2);
    check_log("slow_rv1", rv1_log, '{8'hC3, 8'h3C});
    wait_idle(20);
    check("slow_done1", done1_cnt, 1);
    check("slow_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
